// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line and oversample tick in, received word and status out.
interface uart_rx_param_if #(parameter int NB_DATA = 8);
    logic               rx;
    logic               tick;
    logic [NB_DATA-1:0] data;
    logic               rx_done;
    logic               parity_err;
    logic               frame_err;
    logic               busy;
    modport master (output rx, tick, input data, rx_done, parity_err, frame_err, busy);
    modport slave  (input rx, tick, output data, rx_done, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with 3-sample majority vote, optional parity and 1/2 stop bits.
module uart_rx_param #(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int N_STOP     = 1
) (
    input logic             clk,
    input logic             rst,
    uart_rx_param_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_LO   = TW'(M - 1);
    localparam logic [TW-1:0] T_MID  = TW'(M);
    localparam logic [TW-1:0] T_HI   = TW'(M + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]         samp_q, samp_d;
    logic [NB_DATA-1:0] shift_q, shift_d, data_q, data_d;
    logic               frame_q, frame_d, par_q, par_d;
    logic               done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
    logic               last, s_hi, vote, stop_bad;
    // With OVERSAMPLE=4 the third capture lands on the evaluation tick, so vote on the live sample.
    assign last     = bus.tick && tick_cnt_q == T_LAST;
    assign s_hi     = (tick_cnt_q == T_HI) ? s2_q : samp_q[2];
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & s_hi) | (samp_q[1] & s_hi);
    assign stop_bad = frame_q | ~vote;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            frame_q    <= 1'b0;
            par_q      <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= bus.rx;
            s2_q       <= s1_q;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            frame_q    <= frame_d;
            par_q      <= par_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        data_d     = data_q;
        frame_d    = frame_q;
        par_d      = par_q;
        done_d     = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        if (state_q == IDLE) begin
            if (!s2_q) begin
                state_d    = START;
                tick_cnt_d = '0;
            end
        end else if (state_q == BREAK) begin
            if (s2_q) state_d = IDLE;
        end else if (bus.tick) begin
            tick_cnt_d = last ? '0 : tick_cnt_q + 1'b1;
            if (tick_cnt_q == T_LO)  samp_d[0] = s2_q;
            if (tick_cnt_q == T_MID) samp_d[1] = s2_q;
            if (tick_cnt_q == T_HI)  samp_d[2] = s2_q;
            if (last) begin
                case (state_q)
                    START: begin
                        state_d   = vote ? IDLE : DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end
                    DATA: begin
                        shift_d   = {vote, shift_q[NB_DATA-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BW'(NB_DATA - 1)) begin
                            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                            bit_cnt_d = '0;
                            frame_d   = 1'b0;
                        end
                    end
                    PARITY: begin
                        par_d   = ^shift_q ^ vote ^ 1'(PARITY_ODD);
                        state_d = STOP;
                    end
                    STOP: begin
                        frame_d   = stop_bad;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BW'(N_STOP - 1)) begin
                            done_d  = 1'b1;
                            data_d  = shift_q;
                            perr_d  = (PARITY_EN != 0) && par_q;
                            ferr_d  = stop_bad;
                            state_d = stop_bad ? BREAK : IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    assign bus.data       = data_q;
    assign bus.rx_done    = done_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives 8N1 and 8E2 receivers with serial frames and checks received words against a frame model.
module tb_uart_rx_param;
    typedef struct packed {logic [7:0] d; logic pe; logic fe;} fr_t;
    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
    bit   sel = 1'b0;
    int   pass_cnt = 0, total = 0, div = 0;
    fr_t  q0[$], q1[$];
    uart_rx_param_if #(.NB_DATA(8)) if0 ();
    uart_rx_param_if #(.NB_DATA(8)) if1 ();
    assign if0.rx = rx0;
    assign if0.tick = tick;
    assign if1.rx = rx1;
    assign if1.tick = tick;
    uart_rx_param #(.NB_DATA(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .N_STOP(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    uart_rx_param #(.NB_DATA(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .N_STOP(2))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        div  <= (div == 2) ? 0 : div + 1;
        tick <= (div == 2);
    end
    always @(negedge clk) begin
        if (if0.rx_done === 1'b1) q0.push_back(fr_t'({if0.data, if0.parity_err, if0.frame_err}));
        if (if1.rx_done === 1'b1) q1.push_back(fr_t'({if1.data, if1.parity_err, if1.frame_err}));
    end
    // Even parity: error when data ones plus parity bit is odd; frame error when any stop bit is low.
    function automatic fr_t model(input logic [7:0] d, input bit par_en, input logic parbit,
                                  input logic [1:0] stops, input int nstop);
        fr_t r;
        r.d  = d;
        r.pe = par_en && (($countones(d) + int'(parbit)) % 2 == 1);
        r.fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        return r;
    endfunction
    task automatic set_rx(input logic v);
        if (sel) rx1 = v; else rx0 = v;
    endtask
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask
    task automatic send_bit(input logic v, input bit glitch);
        set_rx(v);
        if (glitch) begin
            wait_ticks(8);
            set_rx(~v);
            wait_ticks(1);
            set_rx(v);
            wait_ticks(7);
        end else wait_ticks(16);
    endtask
    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic parbit,
                              input logic [1:0] stops, input int nstop, input logic [7:0] gmask);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gmask[i]);
        if (par_en) send_bit(parbit, 1'b0);
        for (int i = 0; i < nstop; i++) send_bit(stops[i], 1'b0);
        set_rx(1'b1);
    endtask
    task automatic get_frame(input bit s, output fr_t f, output bit ok);
        int n = 0;
        f = '0;
        ok = 1'b0;
        while (n < 2000 && (s ? q1.size() : q0.size()) == 0) begin
            @(negedge clk);
            n++;
        end
        if (s && q1.size() > 0) begin f = q1.pop_front(); ok = 1'b1; end
        if (!s && q0.size() > 0) begin f = q0.pop_front(); ok = 1'b1; end
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({if0.data, if0.rx_done, if0.parity_err, if0.frame_err, if0.busy} !== 12'h0)
            $display("FAIL reset_dut0 got %h want 0", {if0.data, if0.rx_done, if0.parity_err, if0.frame_err, if0.busy});
        else pass_cnt++;
        total++;
        if ({if1.data, if1.rx_done, if1.parity_err, if1.frame_err, if1.busy} !== 12'h0)
            $display("FAIL reset_dut1 got %h want 0", {if1.data, if1.rx_done, if1.parity_err, if1.frame_err, if1.busy});
        else pass_cnt++;
        rst = 1'b0;
        wait_ticks(4);
    endtask
    task automatic test_single();
        fr_t f, e;
        bit ok;
        sel = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 2'b11, 1, 8'h00);
        get_frame(1'b0, f, ok);
        e = model(8'hA5, 1'b0, 1'b0, 2'b11, 1);
        total++;
        if (!ok || f !== e) $display("FAIL t1_frame got %h ok=%0d want %h", f, ok, e); else pass_cnt++;
        wait_ticks(2);
        total++;
        if (if0.busy !== 1'b0) $display("FAIL t1_busy got %b want 0", if0.busy); else pass_cnt++;
    endtask
    task automatic test_back_to_back();
        logic [7:0] v[3] = '{8'h05, 8'h14, 8'h33};
        fr_t f, e;
        bit ok;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(v[i], 1'b0, 1'b0, 2'b11, 1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            get_frame(1'b0, f, ok);
            e = model(v[i], 1'b0, 1'b0, 2'b11, 1);
            total++;
            if (!ok || f !== e) $display("FAIL t2_frame%0d got %h ok=%0d want %h", i, f, ok, e); else pass_cnt++;
        end
        wait_ticks(4);
    endtask
    task automatic test_glitch_start();
        sel = 1'b0;
        set_rx(1'b0);
        wait_ticks(4);
        set_rx(1'b1);
        wait_ticks(18);
        total++;
        if (q0.size() != 0) $display("FAIL t3_nodone got %0d frames want 0", q0.size()); else pass_cnt++;
        total++;
        if (if0.busy !== 1'b0) $display("FAIL t3_busy got %b want 0", if0.busy); else pass_cnt++;
    endtask
    task automatic test_parity();
        fr_t f, e;
        bit ok;
        sel = 1'b1;
        for (int p = 0; p < 2; p++) begin
            send_frame(8'h07, 1'b1, p[0], 2'b11, 2, 8'h00);
            get_frame(1'b1, f, ok);
            e = model(8'h07, 1'b1, p[0], 2'b11, 2);
            total++;
            if (!ok || f !== e) $display("FAIL t4_parity%0d got %h ok=%0d want %h", p, f, ok, e); else pass_cnt++;
            wait_ticks(2);
        end
        sel = 1'b0;
    endtask
    task automatic test_break();
        fr_t f, e;
        bit ok;
        sel = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'((8'h55 >> i) & 1), 1'b0);
        set_rx(1'b0);
        wait_ticks(56);
        total++;
        if (q0.size() != 1) $display("FAIL t5_count got %0d frames want 1", q0.size()); else pass_cnt++;
        get_frame(1'b0, f, ok);
        e = model(8'h55, 1'b0, 1'b0, 2'b10, 1);
        total++;
        if (!ok || f !== e) $display("FAIL t5_frame got %h ok=%0d want %h", f, ok, e); else pass_cnt++;
        total++;
        if (if0.busy !== 1'b1) $display("FAIL t5_break_busy got %b want 1", if0.busy); else pass_cnt++;
        set_rx(1'b1);
        wait_ticks(4);
        send_frame(8'h3C, 1'b0, 1'b0, 2'b11, 1, 8'h00);
        get_frame(1'b0, f, ok);
        e = model(8'h3C, 1'b0, 1'b0, 2'b11, 1);
        total++;
        if (!ok || f !== e) $display("FAIL t5_after got %h ok=%0d want %h", f, ok, e); else pass_cnt++;
    endtask
    task automatic test_reset_midframe();
        fr_t f, e;
        bit ok;
        sel = 1'b0;
        wait_ticks(2);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        wait_ticks(8);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({if0.data, if0.rx_done, if0.parity_err, if0.frame_err, if0.busy} !== 12'h0)
            $display("FAIL t6_reset got %h want 0", {if0.data, if0.rx_done, if0.parity_err, if0.frame_err, if0.busy});
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        wait_ticks(20);
        send_frame(8'h81, 1'b0, 1'b0, 2'b11, 1, 8'hFF);
        get_frame(1'b0, f, ok);
        e = model(8'h81, 1'b0, 1'b0, 2'b11, 1);
        total++;
        if (!ok || f !== e) $display("FAIL t6_glitch_frame got %h ok=%0d want %h", f, ok, e); else pass_cnt++;
    endtask
    task automatic test_random();
        fr_t exp_q[$];
        fr_t f, e;
        bit ok;
        logic [7:0] d, g;
        logic p;
        logic [1:0] st;
        sel = 1'b0;
        wait_ticks(2);
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            g = 8'($urandom) & 8'($urandom);
            exp_q.push_back(model(d, 1'b0, 1'b0, 2'b11, 1));
            send_frame(d, 1'b0, 1'b0, 2'b11, 1, g);
        end
        for (int i = 0; i < 8; i++) begin
            get_frame(1'b0, f, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || f !== e) $display("FAIL rand8n1_%0d got %h ok=%0d want %h", i, f, ok, e); else pass_cnt++;
        end
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            g = 8'($urandom) & 8'($urandom);
            p = 1'($urandom);
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            send_frame(d, 1'b1, p, st, 2, g);
            wait_ticks(4);
            get_frame(1'b1, f, ok);
            e = model(d, 1'b1, p, st, 2);
            total++;
            if (!ok || f !== e) $display("FAIL rand8e2_%0d got %h ok=%0d want %h", i, f, ok, e); else pass_cnt++;
        end
        sel = 1'b0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch_start();
        test_parity();
        test_break();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
